// File: rtl/mul_array_mac.sv
// mul_array_mac
//   Pipelined array of ARRAY_SIZE independent multiply / multiply-accumulate
//   lanes with valid/ready handshaking on both sides. Each beat carries its
//   own signedness and accumulation-group flags. Accumulating lanes keep a
//   sticky overflow flag. A stall on the output holds the whole pipeline.
//
//   Pipeline:
//     Stage P : per-lane 2*NUM_WIDTH products, p_valid and the beat flags
//     Stage A : per-lane accumulators, sticky flags and the output registers
//
//   Ports:
//     clk          clock, all state updates on the rising edge
//     reset        synchronous active-low reset
//     in_valid     input beat presented
//     in_ready     beat accepted this cycle (= pipeline advances)
//     num_1/num_2  packed lane operands, lane i at [i*NUM_WIDTH +: NUM_WIDTH]
//     signed_mode  1: two's complement operands, 0: unsigned
//     acc_mode     beat belongs to an accumulation group
//     acc_first    first beat of a group (acc_mode=1 only)
//     acc_last     last beat of a group, produces the output (acc_mode=1 only)
//     out_valid    out_num / overflow hold a result
//     out_ready    downstream accepts the result
//     out_num      packed lane results, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//     overflow     per-lane sticky wrap flags
module mul_array_mac #(
  parameter int ARRAY_SIZE = 16,
  parameter int NUM_WIDTH  = 8,
  parameter int ACC_WIDTH  = 2*NUM_WIDTH+4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_WIDTH*ARRAY_SIZE-1:0] num_1,
  input  logic [NUM_WIDTH*ARRAY_SIZE-1:0] num_2,
  input  logic                            signed_mode,
  input  logic                            acc_mode,
  input  logic                            acc_first,
  input  logic                            acc_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ACC_WIDTH*ARRAY_SIZE-1:0] out_num,
  output logic [ARRAY_SIZE-1:0]           overflow
);

  localparam int PW = 2*NUM_WIDTH;
  localparam int AW = ACC_WIDTH;

  logic advance;

  logic p_valid_q, p_signed_q, p_acc_q, p_first_q, p_last_q;
  logic [PW*ARRAY_SIZE-1:0] p_prod_q, p_prod_d;

  logic [AW*ARRAY_SIZE-1:0] acc_q, acc_d;
  logic [AW*ARRAY_SIZE-1:0] out_num_q, out_num_d;
  logic [AW*ARRAY_SIZE-1:0] ext_w, grp_acc_w;
  logic [ARRAY_SIZE-1:0]    sticky_q, sticky_d;
  logic [ARRAY_SIZE-1:0]    overflow_q, overflow_d;
  logic [ARRAY_SIZE-1:0]    grp_ovf_w;
  logic                     out_valid_q, out_valid_d;

  // The only stall source is an unaccepted output; everything else moves.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    logic [NUM_WIDTH-1:0] a, b;
    logic [PW-1:0]        a_ext, b_ext;
    logic [PW-1:0]        prod;
    logic [AW-1:0]        acc, ext;
    logic [AW:0]          sum;
    logic                 add_ovf;

    assign a = num_1[gi*NUM_WIDTH +: NUM_WIDTH];
    assign b = num_2[gi*NUM_WIDTH +: NUM_WIDTH];

    // Extending both operands to PW bits lets one PW x PW multiplier serve
    // both modes: the low PW bits are the exact signed or unsigned product.
    assign a_ext = signed_mode ? {{NUM_WIDTH{a[NUM_WIDTH-1]}}, a} : {{NUM_WIDTH{1'b0}}, a};
    assign b_ext = signed_mode ? {{NUM_WIDTH{b[NUM_WIDTH-1]}}, b} : {{NUM_WIDTH{1'b0}}, b};
    assign p_prod_d[gi*PW +: PW] = a_ext * b_ext;

    assign prod = p_prod_q[gi*PW +: PW];
    assign ext  = p_signed_q ? AW'($signed(prod)) : AW'(prod);
    assign ext_w[gi*AW +: AW] = ext;

    assign acc = acc_q[gi*AW +: AW];
    assign sum = {1'b0, acc} + {1'b0, ext};

    // Signed wrap: equal-sign addends giving a result of the other sign.
    assign add_ovf = p_signed_q ? ((acc[AW-1] == ext[AW-1]) && (sum[AW-1] != acc[AW-1]))
                                : sum[AW];

    assign grp_acc_w[gi*AW +: AW] = p_first_q ? ext : sum[AW-1:0];
    assign grp_ovf_w[gi]          = p_first_q ? 1'b0 : (sticky_q[gi] | add_ovf);
  end

  always_comb begin
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_num_d   = out_num_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    if (p_valid_q) begin
      if (!p_acc_q) begin
        // Plain beat: bypass the accumulators so an open group survives.
        out_valid_d = 1'b1;
        out_num_d   = ext_w;
        overflow_d  = '0;
      end else begin
        acc_d    = grp_acc_w;
        sticky_d = grp_ovf_w;
        if (p_last_q) begin
          out_valid_d = 1'b1;
          out_num_d   = grp_acc_w;
          overflow_d  = grp_ovf_w;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      p_valid_q   <= 1'b0;
      p_signed_q  <= 1'b0;
      p_acc_q     <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_prod_q    <= '0;
      acc_q       <= '0;
      sticky_q    <= '0;
      out_num_q   <= '0;
      overflow_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (advance) begin
      p_valid_q   <= in_valid;
      p_signed_q  <= signed_mode;
      p_acc_q     <= acc_mode;
      p_first_q   <= acc_first;
      p_last_q    <= acc_last;
      p_prod_q    <= p_prod_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_num_q   <= out_num_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_num   = out_num_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mul_array_mac.sv
// Scoreboard bench for mul_array_mac (4 lanes, 8-bit operands, 20-bit results).
// The stimulus process feeds beats and pushes reference results into a queue;
// a monitor pops and compares whenever an output handshake happens.
module tb_mul_array_mac;

  localparam int N  = 4;
  localparam int NW = 8;
  localparam int AW = 20;
  localparam longint MOD  = 64'd1 << AW;
  localparam longint HALF = 64'd1 << (AW-1);

  typedef struct packed {
    logic [AW*N-1:0] num;
    logic [N-1:0]    ovf;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [NW*N-1:0] num_1, num_2;
  logic            signed_mode, acc_mode, acc_first, acc_last;
  logic            out_valid;
  logic            out_ready;
  logic [AW*N-1:0] out_num;
  logic [N-1:0]    overflow;

  mul_array_mac #(.ARRAY_SIZE(N), .NUM_WIDTH(NW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .num_1(num_1), .num_2(num_2), .signed_mode(signed_mode),
    .acc_mode(acc_mode), .acc_first(acc_first), .acc_last(acc_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  longint   m_acc[N];
  logic     m_sticky[N];

  logic [AW*N-1:0] last_out;
  logic [N-1:0]    last_ovf;
  int              out_cnt = 0;
  int              stall_cycles = 0;

  int ready_mode = 0;   // 0: always ready, 1: random
  int stall_cnt  = 0;   // forces out_ready low for this many cycles

  task automatic chk(input string nm, input logic [AW*N-1:0] act, input logic [AW*N-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_acc[i]    = 0;
      m_sticky[i] = 1'b0;
    end
  endfunction

  // Reference: integer arithmetic on the lane values; overflow means the true
  // sum falls outside the representable range of the beat's interpretation.
  function automatic void model_beat(input logic [NW*N-1:0] a, input logic [NW*N-1:0] b,
                                     input logic sg, input logic am, input logic af, input logic al);
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      longint x, y, p, s, cur;
      x = longint'(a[i*NW +: NW]);
      y = longint'(b[i*NW +: NW]);
      if (sg && x >= 128) x -= 256;
      if (sg && y >= 128) y -= 256;
      p = x * y;
      if (!am) begin
        s = p & (MOD - 1);
        e.num[i*AW +: AW] = s[AW-1:0];
        e.ovf[i] = 1'b0;
      end else begin
        if (af) begin
          s = p;
          m_sticky[i] = 1'b0;
        end else begin
          cur = m_acc[i];
          if (sg && cur >= HALF) cur -= MOD;
          s = cur + p;
          if (sg) begin
            if (s < -HALF || s >= HALF) m_sticky[i] = 1'b1;
          end else if (s >= MOD) begin
            m_sticky[i] = 1'b1;
          end
        end
        m_acc[i] = s & (MOD - 1);
        cur = m_acc[i];
        e.num[i*AW +: AW] = cur[AW-1:0];
        e.ovf[i] = m_sticky[i];
      end
    end
    if (!am || al) exp_q.push_back(e);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [NW*N-1:0] a, input logic [NW*N-1:0] b,
                      input logic sg, input logic am, input logic af, input logic al);
    int w;
    num_1 = a; num_2 = b;
    signed_mode = sg; acc_mode = am; acc_first = af; acc_last = al;
    in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 200) break;
    end
    if (w > 200) begin
      chk("accept_timeout", 80'(w), 80'd0);
    end else begin
      model_beat(a, b, sg, am, af, al);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    chk("drain_pending", 80'(exp_q.size()), 80'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else if (ready_mode == 0) begin
        out_ready = 1'b1;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor
  initial begin
    logic            stalled;
    logic [AW*N-1:0] held_num;
    logic [N-1:0]    held_ovf;
    exp_t            e;
    stalled = 1'b0;
    held_num = '0;
    held_ovf = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          stall_cycles++;
          chk("stall_valid_held", 80'(out_valid), 80'd1);
          chk("stall_num_stable", out_num, held_num);
          chk("stall_ovf_stable", 80'(overflow), 80'(held_ovf));
        end
        if (out_valid && !out_ready) chk("stall_in_ready_low", 80'(in_ready), 80'd0);
        if (out_valid && out_ready) begin
          out_cnt++;
          last_out = out_num;
          last_ovf = overflow;
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 80'd1, 80'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_num", out_num, e.num);
            chk("overflow", 80'(overflow), 80'(e.ovf));
          end
        end
        stalled  = out_valid && !out_ready;
        held_num = out_num;
        held_ovf = overflow;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d results pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    num_1 = '0; num_2 = '0;
    signed_mode = 1'b0; acc_mode = 1'b0; acc_first = 1'b0; acc_last = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  80'(in_ready),  80'd1);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_out_num",   out_num,        80'd0);
    chk("rst_overflow",  80'(overflow),  80'd0);
    @(posedge clk); #1;

    // Unsigned non-acc
    send({8'd16, 8'd1, 8'd0, 8'd255}, {8'd16, 8'd200, 8'd77, 8'd255}, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    chk("unsigned_nonacc", last_out, {20'd256, 20'd200, 20'd0, 20'h0FE01});
    chk("unsigned_nonacc_ovf", 80'(last_ovf), 80'd0);

    // Signed non-acc
    send({8'h00, 8'h00, 8'h80, 8'h80}, {8'h00, 8'h00, 8'h7F, 8'h80}, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    chk("signed_nonacc", last_out, {20'd0, 20'd0, 20'hFC080, 20'h04000});

    // Accumulation group with an interleaved plain beat
    c0 = out_cnt;
    send(32'h03030303, 32'h05050505, 1'b0, 1'b1, 1'b1, 1'b0);
    send(32'h02020202, 32'h02020202, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    chk("interleaved_nonacc", last_out, {4{20'd4}});
    chk("acc_partial_outputs", 80'(out_cnt - c0), 80'd1);
    send(32'h03030303, 32'h05050505, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h03030303, 32'h05050505, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h03030303, 32'h05050505, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    chk("acc_sum", last_out, {4{20'd60}});
    chk("acc_output_count", 80'(out_cnt - c0), 80'd2);

    // Overflow: 17 x 255*255 unsigned, then a one-beat group
    for (int k = 0; k < 17; k++)
      send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, (k == 0), (k == 16));
    drain();
    chk("ovf_value", last_out, {4{20'd56849}});
    chk("ovf_flags", 80'(last_ovf), 80'hF);
    send(32'h01010101, 32'h01010101, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();
    chk("ovf_cleared_value", last_out, {4{20'd1}});
    chk("ovf_cleared_flags", 80'(last_ovf), 80'd0);

    // Backpressure: continuous distinct beats, out_ready low for 3 cycles
    c0 = out_cnt;
    stall_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) stall_cnt = 3;
      send({4{8'(k + 1)}}, {4{8'(k + 3)}}, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    drain();
    chk("bp_output_count", 80'(out_cnt - c0), 80'd8);
    chk("bp_stall_seen", 80'(stall_cycles >= 2), 80'd1);

    // Reset mid-stream with an open group and a result in flight
    send(32'h03030303, 32'h05050505, 1'b0, 1'b1, 1'b1, 1'b0);
    send(32'h07070707, 32'h07070707, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out_valid", 80'(out_valid), 80'd0);
    chk("mid_rst_out_num",   out_num,        80'd0);
    chk("mid_rst_overflow",  80'(overflow),  80'd0);
    chk("mid_rst_in_ready",  80'(in_ready),  80'd1);
    @(posedge clk); #1 reset = 1'b1;
    send(32'h03030303, 32'h05050505, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h03030303, 32'h05050505, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    chk("post_rst_group", last_out, {4{20'd30}});

    // Randomized traffic with random backpressure
    ready_mode = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        num_1 = $urandom; num_2 = $urandom;
        @(posedge clk); #1;
      end
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    ready_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
